// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions: per-digit field layout, segment-off level and hex decode.
// Pure declarations; no timing or flow control.
package sseg_pkg;

  localparam int FIELD_W = 6;
  localparam int DP_POS  = 0;
  localparam int HEX_LSB = 1;
  localparam int HEX_W   = 4;
  localparam int EN_POS  = 5;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Matches the bit layout {en, hex[3:0], dp} of one digit_data field.
  typedef struct packed {
    logic       en;
    logic [3:0] hex;
    logic       dp;
  } digit_t;

  // Active-high segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sseg_tick_gen.sv
// Free-running prescaler 0..DIV-1 producing a 1-clk tick on its last count.
// Tick is combinational from the counter; no backpressure.
module sseg_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// Multiplexed N-digit seven-segment scanner with double-buffered data and PWM dimming; pins lag state by 1 clk.
// Optional leading-zero blanking when SSEG_LZB_EN is defined; no backpressure, load is a 1-clk strobe.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int TICK_DIV    = 187_500,
  parameter int BRIGHT_BITS = 4,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DIGITS*FIELD_W-1:0] digit_data,
  input  logic                      load,
  input  logic [BRIGHT_BITS-1:0]    brightness,
  output logic [DIGITS-1:0]         AN,
  output logic [6:0]                sseg,
  output logic                      DP,
  output logic                      frame_done
);

  localparam int   IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic POL = (ACTIVE_LOW != 0);

  logic                      tick;
  logic                      frame_tick;
  logic [IW-1:0]             index;
  logic [BRIGHT_BITS-1:0]    pwm_cnt;
  logic [DIGITS*FIELD_W-1:0] staging;
  logic [DIGITS*FIELD_W-1:0] active;
  logic                      pending;
  logic [DIGITS-1:0]         blank;

  digit_t                    cur;
  logic                      lit;
  logic [DIGITS-1:0]         an_nxt;
  logic [6:0]                seg_nxt;
  logic                      dp_nxt;

  sseg_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign frame_tick = tick && (index == IW'(DIGITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index   <= '0;
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + BRIGHT_BITS'(1);
      if (tick) begin
        index <= (index == IW'(DIGITS - 1)) ? '0 : index + IW'(1);
      end
    end
  end

  // A load coinciding with the frame boundary lands in staging while active
  // takes the previous staging contents, so pending must stay set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staging <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (load) begin
        staging <= digit_data;
      end
      if (frame_tick && pending) begin
        active <= staging;
      end
      if (load) begin
        pending <= 1'b1;
      end else if (frame_tick) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef SSEG_LZB_EN
  logic zero_run;
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run
               && (active[i*FIELD_W + HEX_LSB +: HEX_W] == '0)
               && !active[i*FIELD_W + DP_POS];
      blank[i] = zero_run && (i != 0);
    end
  end
`else
  assign blank = '0;
`endif

  // The tick cycle is kept dark so the segment change never ghosts onto the neighbour digit.
  always_comb begin
    cur     = digit_t'(active[int'(index)*FIELD_W +: FIELD_W]);
    lit     = cur.en && (pwm_cnt < brightness) && !tick && !blank[index];
    an_nxt  = '0;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b0;
    if (lit) begin
      an_nxt[index] = 1'b1;
      seg_nxt       = hex_to_seg(cur.hex);
      dp_nxt        = cur.dp;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      AN         <= {DIGITS{POL}};
      sseg       <= SEG_OFF ^ {7{POL}};
      DP         <= POL;
      frame_done <= 1'b0;
    end else begin
      AN         <= an_nxt ^ {DIGITS{POL}};
      sseg       <= seg_nxt ^ {7{POL}};
      DP         <= dp_nxt ^ POL;
      frame_done <= frame_tick;
    end
  end

endmodule
